// File: rtl/edit_field_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : edit_field_ctrl
// Purpose  : Front-panel editing controller for the clock/date/chrono VGA
//            display. Steps the user through the hour, date and chrono edit
//            groups, highlights the selected field, muxes edited or live BCD
//            values to the display and commits each edited group to the
//            timekeeping block through a req/ack write handshake.
// Ports    : clk, reset (async, active-low)
//            btn_mode/next/up/down/cancel  1-cycle button pulses
//            hora..c_seg                   live packed-BCD values
//            disp_*                        values shown on the display
//            bandera_*                     field-selected highlight flags
//            wr_req/wr_addr/wr_data/wr_ack write handshake
//            edit_active                   high while editing or committing
//            err                           1-cycle pulse on write timeout
// Revision : 1.0  initial release
// ============================================================================
module edit_field_ctrl #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_cancel,
  input  logic [7:0] hora,
  input  logic [7:0] min,
  input  logic [7:0] seg,
  input  logic [7:0] dia,
  input  logic [7:0] mes,
  input  logic [7:0] ano,
  input  logic [7:0] c_hora,
  input  logic [7:0] c_min,
  input  logic [7:0] c_seg,
  output logic [7:0] disp_hora,
  output logic [7:0] disp_min,
  output logic [7:0] disp_seg,
  output logic [7:0] disp_dia,
  output logic [7:0] disp_mes,
  output logic [7:0] disp_ano,
  output logic [7:0] disp_chora,
  output logic [7:0] disp_cmin,
  output logic [7:0] disp_cseg,
  output logic       bandera_hh,
  output logic       bandera_mh,
  output logic       bandera_sh,
  output logic       bandera_df,
  output logic       bandera_mf,
  output logic       bandera_af,
  output logic       bandera_hc,
  output logic       bandera_mc,
  output logic       bandera_sc,
  output logic       wr_req,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_ack,
  output logic       edit_active,
  output logic       err
);

  // Timeout counter only has to reach ACK_TIMEOUT-1.
  localparam int c_cnt_w = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EDIT_H = 3'd1,
    ST_EDIT_F = 3'd2,
    ST_EDIT_C = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  // Group encoding: 0 = hour, 1 = date, 2 = chrono.
  state_t             r_state, w_state_nxt;
  logic [1:0]         r_grp, w_grp_nxt;
  logic [1:0]         r_cursor, w_cursor_nxt;
  logic [1:0]         r_k, w_k_nxt;
  logic [7:0]         r_e0, r_e1, r_e2;
  logic [7:0]         w_e0_nxt, w_e1_nxt, w_e2_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
  logic               r_wr_req, w_wr_req_nxt;
  logic [3:0]         r_wr_addr, w_wr_addr_nxt;
  logic [7:0]         r_wr_data, w_wr_data_nxt;
  logic               r_err, w_err_nxt;
  logic               r_edit_active, w_edit_active_nxt;
  logic [8:0]         r_flags, w_flags_nxt;

  logic [7:0] w_sel_cur, w_sel_k, w_lo, w_hi, w_inc, w_dec;
  logic [3:0] w_flag_idx;

  // Lower/upper bound of the field at (group, cursor); the day limit is
  // deliberately month-independent.
  function automatic logic [7:0] fld_min(input logic [1:0] g, input logic [1:0] c);
    return (g == 2'd1 && c != 2'd2) ? 8'h01 : 8'h00;
  endfunction

  function automatic logic [7:0] fld_max(input logic [1:0] g, input logic [1:0] c);
    if (g == 2'd1) begin
      case (c)
        2'd0:    return 8'h31;
        2'd1:    return 8'h12;
        default: return 8'h99;
      endcase
    end
    return (c == 2'd0) ? 8'h23 : 8'h59;
  endfunction

  function automatic logic [3:0] grp_base(input logic [1:0] g);
    case (g)
      2'd0:    return 4'd0;
      2'd1:    return 4'd3;
      default: return 4'd6;
    endcase
  endfunction

  // Packed-BCD step with wrap. Out-of-range inputs (e.g. a day snapshot of
  // 00) are pulled back into range so the result is always valid BCD.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (v >= hi)            return lo;
    else if (v < lo)        return lo;
    else if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                    return v + 8'd1;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (v <= lo || v > hi)   return hi;
    else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else if (v[3:0] > 4'd9)  return {v[7:4], 4'd9};
    else                     return v - 8'd1;
  endfunction

  always_comb begin
    case (r_cursor)
      2'd0:    w_sel_cur = r_e0;
      2'd1:    w_sel_cur = r_e1;
      default: w_sel_cur = r_e2;
    endcase
    case (r_k)
      2'd0:    w_sel_k = r_e0;
      2'd1:    w_sel_k = r_e1;
      default: w_sel_k = r_e2;
    endcase
  end

  assign w_lo  = fld_min(r_grp, r_cursor);
  assign w_hi  = fld_max(r_grp, r_cursor);
  assign w_inc = bcd_inc(w_sel_cur, w_lo, w_hi);
  assign w_dec = bcd_dec(w_sel_cur, w_lo, w_hi);

  // Next-state logic; all outputs are registered from these values so the
  // flags and edit_active line up with the state they describe.
  always_comb begin
    w_state_nxt   = r_state;
    w_grp_nxt     = r_grp;
    w_cursor_nxt  = r_cursor;
    w_k_nxt       = r_k;
    w_e0_nxt      = r_e0;
    w_e1_nxt      = r_e1;
    w_e2_nxt      = r_e2;
    w_cnt_nxt     = r_cnt;
    w_wr_req_nxt  = r_wr_req;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_err_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (btn_mode) begin
          w_state_nxt  = ST_EDIT_H;
          w_grp_nxt    = 2'd0;
          w_cursor_nxt = 2'd0;
          w_e0_nxt     = hora;
          w_e1_nxt     = min;
          w_e2_nxt     = seg;
        end
      end

      ST_EDIT_H, ST_EDIT_F, ST_EDIT_C: begin
        // Priority chain: cancel > mode > next > up > down.
        if (btn_cancel) begin
          w_state_nxt = ST_IDLE;
        end else if (btn_mode) begin
          w_state_nxt   = ST_COMMIT;
          w_k_nxt       = 2'd0;
          w_wr_req_nxt  = 1'b1;
          w_wr_addr_nxt = grp_base(r_grp);
          w_wr_data_nxt = r_e0;
          w_cnt_nxt     = '0;
        end else if (btn_next) begin
          w_cursor_nxt = (r_cursor == 2'd2) ? 2'd0 : r_cursor + 2'd1;
        end else if (btn_up || btn_down) begin
          case (r_cursor)
            2'd0:    w_e0_nxt = btn_up ? w_inc : w_dec;
            2'd1:    w_e1_nxt = btn_up ? w_inc : w_dec;
            default: w_e2_nxt = btn_up ? w_inc : w_dec;
          endcase
        end
      end

      ST_COMMIT: begin
        if (r_wr_req) begin
          if (wr_ack) begin
            w_wr_req_nxt = 1'b0;
            if (r_k == 2'd2) begin
              w_cursor_nxt = 2'd0;
              case (r_grp)
                2'd0: begin
                  w_state_nxt = ST_EDIT_F;
                  w_grp_nxt   = 2'd1;
                  w_e0_nxt    = dia;
                  w_e1_nxt    = mes;
                  w_e2_nxt    = ano;
                end
                2'd1: begin
                  w_state_nxt = ST_EDIT_C;
                  w_grp_nxt   = 2'd2;
                  w_e0_nxt    = c_hora;
                  w_e1_nxt    = c_min;
                  w_e2_nxt    = c_seg;
                end
                default: w_state_nxt = ST_IDLE;
              endcase
            end else begin
              w_k_nxt = r_k + 2'd1;
            end
          end else if (r_cnt == c_cnt_last) begin
            w_wr_req_nxt = 1'b0;
            w_err_nxt    = 1'b1;
            w_state_nxt  = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else begin
          // One idle cycle after each ack, then raise the next write.
          w_wr_req_nxt  = 1'b1;
          w_wr_addr_nxt = grp_base(r_grp) + {2'b00, r_k};
          w_wr_data_nxt = w_sel_k;
          w_cnt_nxt     = '0;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    w_flag_idx        = grp_base(w_grp_nxt) + {2'b00, w_cursor_nxt};
    w_edit_active_nxt = (w_state_nxt != ST_IDLE);
    if (w_state_nxt == ST_EDIT_H || w_state_nxt == ST_EDIT_F || w_state_nxt == ST_EDIT_C)
      w_flags_nxt = 9'b0_0000_0001 << w_flag_idx;
    else
      w_flags_nxt = 9'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_grp         <= 2'd0;
      r_cursor      <= 2'd0;
      r_k           <= 2'd0;
      r_e0          <= 8'h00;
      r_e1          <= 8'h00;
      r_e2          <= 8'h00;
      r_cnt         <= '0;
      r_wr_req      <= 1'b0;
      r_wr_addr     <= 4'd0;
      r_wr_data     <= 8'h00;
      r_err         <= 1'b0;
      r_edit_active <= 1'b0;
      r_flags       <= 9'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grp         <= w_grp_nxt;
      r_cursor      <= w_cursor_nxt;
      r_k           <= w_k_nxt;
      r_e0          <= w_e0_nxt;
      r_e1          <= w_e1_nxt;
      r_e2          <= w_e2_nxt;
      r_cnt         <= w_cnt_nxt;
      r_wr_req      <= w_wr_req_nxt;
      r_wr_addr     <= w_wr_addr_nxt;
      r_wr_data     <= w_wr_data_nxt;
      r_err         <= w_err_nxt;
      r_edit_active <= w_edit_active_nxt;
      r_flags       <= w_flags_nxt;
    end
  end

  // A group shows its edit registers while being edited or committed.
  logic w_show_h, w_show_f, w_show_c;
  assign w_show_h = (r_state != ST_IDLE) && (r_grp == 2'd0);
  assign w_show_f = (r_state != ST_IDLE) && (r_grp == 2'd1);
  assign w_show_c = (r_state != ST_IDLE) && (r_grp == 2'd2);

  assign disp_hora  = w_show_h ? r_e0 : hora;
  assign disp_min   = w_show_h ? r_e1 : min;
  assign disp_seg   = w_show_h ? r_e2 : seg;
  assign disp_dia   = w_show_f ? r_e0 : dia;
  assign disp_mes   = w_show_f ? r_e1 : mes;
  assign disp_ano   = w_show_f ? r_e2 : ano;
  assign disp_chora = w_show_c ? r_e0 : c_hora;
  assign disp_cmin  = w_show_c ? r_e1 : c_min;
  assign disp_cseg  = w_show_c ? r_e2 : c_seg;

  assign bandera_hh = r_flags[0];
  assign bandera_mh = r_flags[1];
  assign bandera_sh = r_flags[2];
  assign bandera_df = r_flags[3];
  assign bandera_mf = r_flags[4];
  assign bandera_af = r_flags[5];
  assign bandera_hc = r_flags[6];
  assign bandera_mc = r_flags[7];
  assign bandera_sc = r_flags[8];

  assign wr_req      = r_wr_req;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign err         = r_err;
  assign edit_active = r_edit_active;

endmodule
`default_nettype wire

// File: tb/tb_edit_field_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_edit_field_ctrl
// Purpose  : Directed self-checking bench for edit_field_ctrl: reset state,
//            hour/date/chrono editing with BCD wrap, commit handshake,
//            timeout, cancel and asynchronous reset during a commit.
// Revision : 1.0  initial release
// ============================================================================
module tb_edit_field_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_next, btn_up, btn_down, btn_cancel;
  logic [7:0] hora, min, seg, dia, mes, ano, c_hora, c_min, c_seg;
  logic [7:0] disp_hora, disp_min, disp_seg, disp_dia, disp_mes, disp_ano;
  logic [7:0] disp_chora, disp_cmin, disp_cseg;
  logic       bandera_hh, bandera_mh, bandera_sh, bandera_df, bandera_mf;
  logic       bandera_af, bandera_hc, bandera_mc, bandera_sc;
  logic       wr_req, wr_ack, edit_active, err;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [8:0] flags;

  int total = 0;
  int bad   = 0;
  logic saw_req = 1'b0;

  always #5 clk = ~clk;

  assign flags = {bandera_sc, bandera_mc, bandera_hc, bandera_af, bandera_mf,
                  bandera_df, bandera_sh, bandera_mh, bandera_hh};

  always @(posedge clk) if (wr_req === 1'b1) saw_req = 1'b1;

  edit_field_ctrl #(.ACK_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up),
    .btn_down(btn_down), .btn_cancel(btn_cancel),
    .hora(hora), .min(min), .seg(seg), .dia(dia), .mes(mes), .ano(ano),
    .c_hora(c_hora), .c_min(c_min), .c_seg(c_seg),
    .disp_hora(disp_hora), .disp_min(disp_min), .disp_seg(disp_seg),
    .disp_dia(disp_dia), .disp_mes(disp_mes), .disp_ano(disp_ano),
    .disp_chora(disp_chora), .disp_cmin(disp_cmin), .disp_cseg(disp_cseg),
    .bandera_hh(bandera_hh), .bandera_mh(bandera_mh), .bandera_sh(bandera_sh),
    .bandera_df(bandera_df), .bandera_mf(bandera_mf), .bandera_af(bandera_af),
    .bandera_hc(bandera_hc), .bandera_mc(bandera_mc), .bandera_sc(bandera_sc),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .edit_active(edit_active), .err(err)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic n, input logic u,
                       input logic d, input logic c);
    btn_mode = m; btn_next = n; btn_up = u; btn_down = d; btn_cancel = c;
    tick();
    btn_mode = 0; btn_next = 0; btn_up = 0; btn_down = 0; btn_cancel = 0;
  endtask

  task automatic test_reset();
    reset = 0; wr_ack = 0;
    btn_mode = 0; btn_next = 0; btn_up = 0; btn_down = 0; btn_cancel = 0;
    hora = 8'h12; min = 8'h34; seg = 8'h56;
    dia = 8'h01; mes = 8'h01; ano = 8'h24;
    c_hora = 8'h20; c_min = 8'h00; c_seg = 8'h45;
    tick(); tick();
    total++; if (flags !== 9'h000) begin bad++; $display("FAIL reset_flags got=%h exp=000", flags); end
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL reset_wr_req got=%b exp=0", wr_req); end
    total++; if (disp_hora !== 8'h12) begin bad++; $display("FAIL reset_disp_hora got=%h exp=12", disp_hora); end
    total++; if (disp_min !== 8'h34) begin bad++; $display("FAIL reset_disp_min got=%h exp=34", disp_min); end
    total++; if ({edit_active, err, wr_addr, wr_data} !== 14'h0) begin
      bad++; $display("FAIL reset_misc got=%b/%b/%h/%h exp=0/0/0/00", edit_active, err, wr_addr, wr_data);
    end
    reset = 1;
    tick();
  endtask

  task automatic test_edit_hour();
    logic [7:0] exp_up [12] = '{8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18,
                                8'h19, 8'h20, 8'h21, 8'h22, 8'h23, 8'h00};
    min = 8'h00; seg = 8'h01;
    press(1, 0, 0, 0, 0);
    total++; if (flags !== 9'h001) begin bad++; $display("FAIL edit_h_flags got=%h exp=001", flags); end
    total++; if (edit_active !== 1'b1) begin bad++; $display("FAIL edit_h_active got=%b exp=1", edit_active); end
    total++; if (disp_hora !== 8'h12) begin bad++; $display("FAIL edit_h_snap got=%h exp=12", disp_hora); end
    for (int i = 0; i < 12; i++) begin
      if (i == 5) hora = 8'h05;  // live change must not reach the display
      press(0, 0, 1, 0, 0);
      total++; if (disp_hora !== exp_up[i]) begin
        bad++; $display("FAIL hour_up_%0d got=%h exp=%h", i, disp_hora, exp_up[i]);
      end
    end
    total++; if (flags !== 9'h001) begin bad++; $display("FAIL edit_h_flags2 got=%h exp=001", flags); end
    total++; if (disp_dia !== 8'h01) begin bad++; $display("FAIL edit_h_live_dia got=%h exp=01", disp_dia); end
    press(0, 0, 0, 1, 0);
    total++; if (disp_hora !== 8'h23) begin bad++; $display("FAIL hour_down_wrap got=%h exp=23", disp_hora); end
    press(0, 1, 0, 0, 0);
    total++; if (flags !== 9'h002) begin bad++; $display("FAIL edit_h_next1 got=%h exp=002", flags); end
    press(0, 0, 0, 1, 0);
    total++; if (disp_min !== 8'h59) begin bad++; $display("FAIL min_down_wrap got=%h exp=59", disp_min); end
    press(0, 1, 0, 0, 0);
    total++; if (flags !== 9'h004) begin bad++; $display("FAIL edit_h_next2 got=%h exp=004", flags); end
    press(0, 0, 0, 1, 0);
    total++; if (disp_seg !== 8'h00) begin bad++; $display("FAIL seg_down got=%h exp=00", disp_seg); end
  endtask

  task automatic test_commit_hour();
    logic [7:0] exp_d [3] = '{8'h23, 8'h59, 8'h00};
    press(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      total++; if (wr_req !== 1'b1 || wr_addr !== 4'(k) || wr_data !== exp_d[k]) begin
        bad++; $display("FAIL commit_h_wr%0d got=%b/%0d/%h exp=1/%0d/%h", k, wr_req, wr_addr, wr_data, k, exp_d[k]);
      end
      total++; if (flags !== 9'h000 || disp_hora !== 8'h23) begin
        bad++; $display("FAIL commit_h_view%0d got=%h/%h exp=000/23", k, flags, disp_hora);
      end
      tick();
      total++; if (wr_req !== 1'b1 || wr_addr !== 4'(k) || wr_data !== exp_d[k]) begin
        bad++; $display("FAIL commit_h_hold%0d got=%b/%0d/%h exp=1/%0d/%h", k, wr_req, wr_addr, wr_data, k, exp_d[k]);
      end
      wr_ack = 1; tick(); wr_ack = 0;
      total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL commit_h_gap%0d got=%b exp=0", k, wr_req); end
      if (k < 2) begin
        if (k == 0) wr_ack = 1;  // ack during the idle cycle must be ignored
        tick();
        wr_ack = 0;
      end
    end
    total++; if (flags !== 9'h008) begin bad++; $display("FAIL commit_h_to_f got=%h exp=008", flags); end
    total++; if (disp_hora !== 8'h05) begin bad++; $display("FAIL commit_h_live got=%h exp=05", disp_hora); end
  endtask

  task automatic test_edit_date();
    logic [7:0] exp_d [3] = '{8'h01, 8'h12, 8'h24};
    int w;
    press(0, 1, 0, 0, 0);
    press(0, 0, 0, 1, 0);
    total++; if (flags !== 9'h010 || disp_mes !== 8'h12) begin
      bad++; $display("FAIL month_down got=%h/%h exp=010/12", flags, disp_mes);
    end
    press(0, 1, 1, 0, 0);
    total++; if (flags !== 9'h020 || disp_mes !== 8'h12 || disp_ano !== 8'h24) begin
      bad++; $display("FAIL next_over_up got=%h/%h/%h exp=020/12/24", flags, disp_mes, disp_ano);
    end
    press(0, 1, 0, 0, 0);
    total++; if (flags !== 9'h008) begin bad++; $display("FAIL cursor_wrap got=%h exp=008", flags); end
    press(0, 0, 0, 1, 0);
    total++; if (disp_dia !== 8'h31) begin bad++; $display("FAIL day_down_wrap got=%h exp=31", disp_dia); end
    press(0, 0, 1, 0, 0);
    total++; if (disp_dia !== 8'h01) begin bad++; $display("FAIL day_up_wrap got=%h exp=01", disp_dia); end
    press(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      w = 0;
      while (wr_req !== 1'b1 && w < 5) begin tick(); w++; end
      total++; if (wr_req !== 1'b1 || wr_addr !== 4'(3 + k) || wr_data !== exp_d[k]) begin
        bad++; $display("FAIL commit_f_wr%0d got=%b/%0d/%h exp=1/%0d/%h", k, wr_req, wr_addr, wr_data, 3 + k, exp_d[k]);
      end
      wr_ack = 1; tick(); wr_ack = 0;
    end
    total++; if (flags !== 9'h040 || disp_chora !== 8'h20) begin
      bad++; $display("FAIL commit_f_to_c got=%h/%h exp=040/20", flags, disp_chora);
    end
  endtask

  task automatic test_cancel();
    tick();
    saw_req = 0;
    press(0, 0, 0, 1, 0);
    total++; if (disp_chora !== 8'h19) begin bad++; $display("FAIL chora_down_carry got=%h exp=19", disp_chora); end
    press(0, 1, 0, 0, 0);
    press(0, 0, 0, 1, 0);
    c_seg = 8'h46;
    total++; if (disp_cmin !== 8'h59 || disp_cseg !== 8'h45 || flags !== 9'h080) begin
      bad++; $display("FAIL chrono_edit got=%h/%h/%h exp=59/45/080", disp_cmin, disp_cseg, flags);
    end
    press(1, 0, 0, 0, 1);  // cancel outranks mode
    total++; if (flags !== 9'h000 || edit_active !== 1'b0) begin
      bad++; $display("FAIL cancel_state got=%h/%b exp=000/0", flags, edit_active);
    end
    total++; if (disp_chora !== 8'h20 || disp_cmin !== 8'h00 || disp_cseg !== 8'h46) begin
      bad++; $display("FAIL cancel_live got=%h/%h/%h exp=20/00/46", disp_chora, disp_cmin, disp_cseg);
    end
    press(0, 1, 1, 0, 0);
    tick();
    total++; if (flags !== 9'h000 || edit_active !== 1'b0 || saw_req !== 1'b0) begin
      bad++; $display("FAIL cancel_idle got=%h/%b/%b exp=000/0/0", flags, edit_active, saw_req);
    end
  endtask

  task automatic test_timeout();
    int n_req, n_err;
    n_req = 0; n_err = 0;
    press(1, 0, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (wr_req === 1'b1) n_req++;
      if (err === 1'b1) n_err++;
      btn_cancel = (i == 2);  // ignored while committing
      tick();
    end
    btn_cancel = 0;
    total++; if (n_req !== 8) begin bad++; $display("FAIL timeout_req_cycles got=%0d exp=8", n_req); end
    total++; if (n_err !== 1) begin bad++; $display("FAIL timeout_err_pulses got=%0d exp=1", n_err); end
    total++; if (edit_active !== 1'b0 || flags !== 9'h000) begin
      bad++; $display("FAIL timeout_idle got=%b/%h exp=0/000", edit_active, flags);
    end
  endtask

  task automatic test_reset_mid_commit();
    press(1, 0, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    wr_ack = 1; tick(); wr_ack = 0;
    tick();
    total++; if (wr_req !== 1'b1 || wr_addr !== 4'd1) begin
      bad++; $display("FAIL mid_second_write got=%b/%0d exp=1/1", wr_req, wr_addr);
    end
    #1 reset = 0;
    #1;
    total++; if (wr_req !== 1'b0 || wr_addr !== 4'd0 || edit_active !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%b/%0d/%b exp=0/0/0", wr_req, wr_addr, edit_active);
    end
    #1 reset = 1;
    tick();
    total++; if (wr_req !== 1'b0 || edit_active !== 1'b0) begin
      bad++; $display("FAIL after_reset_idle got=%b/%b exp=0/0", wr_req, edit_active);
    end
    press(1, 0, 0, 0, 0);
    total++; if (flags !== 9'h001 || disp_hora !== 8'h05) begin
      bad++; $display("FAIL restart_edit got=%h/%h exp=001/05", flags, disp_hora);
    end
  endtask

  initial begin
    test_reset();
    test_edit_hour();
    test_commit_hour();
    test_edit_date();
    test_cancel();
    test_timeout();
    test_reset_mid_commit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edit_field_ctrl.md
Name: edit_field_ctrl

Overview:
- Front-panel editing controller for the clock/date/chronometer VGA display.
- Sequences the user through the hour, date and chrono edit groups and drives the nine per-field highlight flags (bandera_*).
- Muxes edited or live BCD values onto the display data inputs.
- Commits each edited group to the RTC/timekeeping interface through a req/ack write handshake.

Parameters:
- ACK_TIMEOUT, 255: cycles to wait for wr_ack before aborting a commit.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_mode  in  1  1-cycle pulse: enter, advance or commit the edit group.
- btn_next  in  1  1-cycle pulse: move the cursor to the next field in the group.
- btn_up  in  1  1-cycle pulse: increment the selected field.
- btn_down  in  1  1-cycle pulse: decrement the selected field.
- btn_cancel  in  1  1-cycle pulse: leave editing with no writes.
- hora, min, seg, dia, mes, ano, c_hora, c_min, c_seg  in  8 each  live packed-BCD values.
- disp_hora, disp_min, disp_seg, disp_dia, disp_mes, disp_ano, disp_chora, disp_cmin, disp_cseg  out  8 each  values to the display.
- bandera_hh, bandera_mh, bandera_sh, bandera_df, bandera_mf, bandera_af, bandera_hc, bandera_mc, bandera_sc  out  1 each  field-selected flags.
- wr_req  out  1  write request.
- wr_addr  out  4  field index: 0=hh, 1=mh, 2=sh, 3=df, 4=mf, 5=af, 6=hc, 7=mc, 8=sc.
- wr_data  out  8  packed BCD value to write.
- wr_ack  in  1  write accepted.
- edit_active  out  1  high in any EDIT or COMMIT state.
- err  out  1  1-cycle pulse on write timeout.

Behaviour:
- Reset (async, active-low):
  - state=IDLE, cursor=0, edit registers=8'h00.
  - All bandera_*, wr_req, err, edit_active = 0; wr_addr=0, wr_data=0.
  - disp_* follow the live inputs.
- States: IDLE, EDIT_H, EDIT_F, EDIT_C, COMMIT.
- Group to next edit state: H to EDIT_F, F to EDIT_C, C to IDLE.
- Button priority when several pulse in the same cycle: cancel > mode > next > up > down. Only one action per cycle.
- IDLE:
  - btn_mode snapshots hora/min/seg into e0/e1/e2, sets cursor=0 and enters EDIT_H.
  - All other buttons are ignored.
- EDIT_x (x = H, F, C):
  - Exactly one bandera of the group is high, selected by cursor: H uses hh/mh/sh, F uses df/mf/af, C uses hc/mc/sc.
  - disp_* for the group show e0..e2; the other groups show live values.
  - btn_next: cursor 0 to 1 to 2 to 0.
  - btn_up / btn_down: BCD increment/decrement of e[cursor] with wrap.
    - Hour fields 00..23; min/sec fields 00..59; day 01..31; month 01..12; year 00..99.
    - The day limit does not depend on the month.
    - Examples: up from the max wraps to the min (23 to 00, 31 to 01); down from the min wraps to the max (00 to 23, 01 to 12).
    - The result is always valid BCD; low nibble carries into the high nibble (19 to 20, 20 to 19 on down).
  - btn_cancel: go to IDLE with no writes; flags drop the next cycle.
  - btn_mode: go to COMMIT for this group with write index k=0.
- COMMIT:
  - Bandera flags are low; disp_* keep showing the edit registers.
  - Buttons are ignored, including cancel.
  - Writes are issued in order k=0,1,2: wr_addr = group base (0/3/6) + k, wr_data = e[k], wr_req=1.
  - wr_req, wr_addr and wr_data stay stable until a rising edge samples wr_ack=1.
  - wr_req drops on the next cycle.
  - There is at least one idle cycle with wr_req=0 before the next write.
  - An ack while wr_req=0 is ignored.
  - After the third ack:
    - Group H or F: snapshot the next group's live values, cursor=0, enter the next EDIT state.
    - Group C: go to IDLE.
- Timeout:
  - A counter is cleared when each request is raised.
  - If ACK_TIMEOUT cycles pass with no ack: drop wr_req, pulse err for one cycle, go to IDLE.
  - Writes already acknowledged are not retried.
- Reset asserted mid-COMMIT drops wr_req asynchronously; no partial-state recovery.
- edit_active is a registered decode of state.

Test Plan:
- Reset with hora=8'h12, min=8'h34:
  - All flags=0, wr_req=0.
  - disp_hora=12, disp_min=34.
- btn_mode, then btn_up x12 with hora=8'h12:
  - bandera_hh=1 only; disp_hora steps 13..23, then wraps to 00.
  - Live hora changes are not shown on disp_hora.
- In EDIT_F with dia=8'h01: btn_next to mes=01, then btn_down:
  - bandera_mf=1, disp_mes=12.
  - Same-cycle btn_next+btn_up performs only the next.
- Commit EDIT_H with e=23/59/00, ack after 2 cycles each:
  - Writes (0,23), (1,59), (2,00) in order, each followed by an idle cycle.
  - Then EDIT_F with bandera_df=1.
- Commit with wr_ack held low, ACK_TIMEOUT=8:
  - wr_req high for 8 cycles, err pulses once, state returns to IDLE.
- btn_cancel in EDIT_C after edits:
  - No wr_req ever; the next cycle shows flags=0 and disp_* equal to the live values.
- Reset pulsed during the second write:
  - wr_req=0 immediately and the block restarts in IDLE.
